xbar_dbuf: RTL and testbench



---
 rtl/xbar_pkg.sv | 30 +++
 rtl/xbar_cfg_loader.sv | 104 ++++++++++
 rtl/xbar_dbuf.sv | 66 ++++++
 tb/tb_xbar_dbuf.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types and elaboration-time helpers for the double-buffered LUT-input crossbar.
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } cfg_state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

    function automatic int calc_tot_w(input int n_out, input int sel_w);
        return n_out * sel_w;
    endfunction

    function automatic int calc_words(input int tot_w, input int cfg_w);
        return (tot_w + cfg_w - 1) / cfg_w;
    endfunction

endpackage

// File: rtl/xbar_cfg_loader.sv
// Select-vector loader: word-by-word fill of a shadow register, atomic commit to active.
module xbar_cfg_loader
    import xbar_pkg::*;
#(
    parameter int TOT_W = 140,
    parameter int CFG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_commit,
    input  logic             cfg_clear,
    output logic             cfg_full,
    output logic             cfg_err,
    output logic [TOT_W-1:0] active,
    output cfg_state_e       dbg_state
);

    localparam int WORDS = calc_words(TOT_W, CFG_W);
    localparam int CNT_W = clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    cfg_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [TOT_W-1:0] shadow, shadow_nxt;
    logic             err_nxt;
    logic             do_commit;
    logic             accept;

    // Handshake: a word moves on any edge where cfg_valid && cfg_ready; cfg_ready
    // depends only on state, never on cfg_valid. Clear drops a word offered alongside it.
    assign cfg_ready = (state != FULL);
    assign cfg_full  = (state == FULL);
    assign accept    = cfg_valid && cfg_ready && !cfg_clear;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        do_commit = 1'b0;
        if (cfg_clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    err_nxt = cfg_commit;
                    if (accept) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = (WORDS == 1) ? FULL : LOAD;
                    end
                end
                LOAD: begin
                    err_nxt = cfg_commit;
                    if (accept) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == LAST_IDX) state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (cfg_commit) begin
                        do_commit = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Word cnt lands at shadow[cnt*CFG_W +: CFG_W]; bits past TOT_W in the last word are dropped.
    always_comb begin
        shadow_nxt = shadow;
        if (accept) begin
            for (int j = 0; j < TOT_W; j++) begin
                if (int'(cnt) == j / CFG_W) shadow_nxt[j] = cfg_data[j % CFG_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shadow  <= '0;
            active  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shadow  <= shadow_nxt;
            cfg_err <= err_nxt;
            if (do_commit) active <= shadow;
        end
    end

endmodule

// File: rtl/xbar_dbuf.sv
// LUT-tile input crossbar: each output picks one input by a committed select field,
// optionally registered to break the routing-to-LUT path.
module xbar_dbuf
    import xbar_pkg::*;
#(
    parameter int N_IN    = 24,
    parameter int N_OUT   = 28,
    parameter int SEL_W   = clog2(N_IN),
    parameter int CFG_W   = 32,
    parameter int OUT_REG = 1,
    localparam int TOT_W  = calc_tot_w(N_OUT, SEL_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  io_xbar_in,
    output logic [N_OUT-1:0] io_xbar_out,
    input  logic [CFG_W-1:0] io_cfg_data,
    input  logic             io_cfg_valid,
    output logic             io_cfg_ready,
    input  logic             io_cfg_commit,
    input  logic             io_cfg_clear,
    output logic             io_cfg_full,
    output logic             io_cfg_err,
    output logic [TOT_W-1:0] io_active_cfg,
    output cfg_state_e       dbg_cfg_state
);

    logic [TOT_W-1:0] active;
    logic [N_OUT-1:0] mux_out;

    xbar_cfg_loader #(
        .TOT_W (TOT_W),
        .CFG_W (CFG_W)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .cfg_data   (io_cfg_data),
        .cfg_valid  (io_cfg_valid),
        .cfg_ready  (io_cfg_ready),
        .cfg_commit (io_cfg_commit),
        .cfg_clear  (io_cfg_clear),
        .cfg_full   (io_cfg_full),
        .cfg_err    (io_cfg_err),
        .active     (active),
        .dbg_state  (dbg_cfg_state)
    );

    assign io_active_cfg = active;

    // Select codes beyond the last input park the output at 0.
    for (genvar g = 0; g < N_OUT; g++) begin : g_sel
        logic [SEL_W-1:0] sel;
        assign sel        = active[g*SEL_W +: SEL_W];
        assign mux_out[g] = (int'(sel) < N_IN) ? io_xbar_in[sel] : 1'b0;
    end

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk) begin
            if (reset) io_xbar_out <= '0;
            else       io_xbar_out <= mux_out;
        end
    end else begin : g_out_comb
        assign io_xbar_out = mux_out;
    end

endmodule

// File: tb/tb_xbar_dbuf.sv
// Bench for xbar_dbuf (default parameters, registered outputs): a word-count model of the
// loader checked every cycle, plus hand-computed expectations for each scenario.
module tb_xbar_dbuf;
    import xbar_pkg::*;

    localparam int N_IN  = 24;
    localparam int N_OUT = 28;
    localparam int SEL_W = 5;
    localparam int CFG_W = 32;
    localparam int TOT_W = 140;
    localparam int WORDS = 5;
    localparam int PAD_W = WORDS * CFG_W;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset      = 1'b1;
    logic [N_IN-1:0]  xbar_in    = '0;
    logic [N_OUT-1:0] xbar_out;
    logic [CFG_W-1:0] cfg_data   = '0;
    logic             cfg_valid  = 1'b0;
    logic             cfg_ready;
    logic             cfg_commit = 1'b0;
    logic             cfg_clear  = 1'b0;
    logic             cfg_full;
    logic             cfg_err;
    logic [TOT_W-1:0] active_cfg;
    cfg_state_e       cfg_state;

    xbar_dbuf dut (
        .clk           (clk),
        .reset         (reset),
        .io_xbar_in    (xbar_in),
        .io_xbar_out   (xbar_out),
        .io_cfg_data   (cfg_data),
        .io_cfg_valid  (cfg_valid),
        .io_cfg_ready  (cfg_ready),
        .io_cfg_commit (cfg_commit),
        .io_cfg_clear  (cfg_clear),
        .io_cfg_full   (cfg_full),
        .io_cfg_err    (cfg_err),
        .io_active_cfg (active_cfg),
        .dbg_cfg_state (cfg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [TOT_W-1:0] got, input logic [TOT_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // helpers to describe configurations
    function automatic logic [TOT_W-1:0] fill(input int v);
        logic [TOT_W-1:0] c;
        for (int k = 0; k < N_OUT; k++) c[k*SEL_W +: SEL_W] = SEL_W'(v);
        return c;
    endfunction

    function automatic logic [N_OUT-1:0] route(input logic [N_IN-1:0] din, input logic [TOT_W-1:0] act);
        logic [N_OUT-1:0] o;
        int s;
        for (int k = 0; k < N_OUT; k++) begin
            s    = int'(act[k*SEL_W +: SEL_W]);
            o[k] = (s < N_IN) ? din[s] : 1'b0;
        end
        return o;
    endfunction

    function automatic logic [CFG_W-1:0] word_of(input logic [TOT_W-1:0] c, input int i);
        logic [PAD_W-1:0] pad;
        pad = '0;
        pad[TOT_W-1:0] = c;
        return pad[i*CFG_W +: CFG_W];
    endfunction

    // scoreboard model: loader described as "how many words are buffered"
    int               m_cnt    = 0;
    logic [PAD_W-1:0] m_pad    = '0;
    logic [TOT_W-1:0] m_active = '0;
    logic             m_err    = 1'b0;
    logic [N_OUT-1:0] exp_out  = '0;
    bit               armed    = 1'b0;

    function automatic cfg_state_e state_of(input int cnt);
        if (cnt == 0)     return IDLE;
        if (cnt == WORDS) return FULL;
        return LOAD;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            check("out", TOT_W'(xbar_out), TOT_W'(exp_out));
            check("active", active_cfg, m_active);
            check("ready", TOT_W'(cfg_ready), TOT_W'(m_cnt < WORDS));
            check("full", TOT_W'(cfg_full), TOT_W'(m_cnt == WORDS));
            check("err", TOT_W'(cfg_err), TOT_W'(m_err));
            check("state", TOT_W'(cfg_state), TOT_W'(state_of(m_cnt)));
        end
        // predict the effect of the coming edge from the inputs now on the pins
        if (reset) begin
            m_cnt    = 0;
            m_pad    = '0;
            m_active = '0;
            m_err    = 1'b0;
            exp_out  = '0;
            armed    = 1'b1;
        end else begin
            exp_out = route(xbar_in, m_active);
            m_err   = 1'b0;
            if (cfg_clear) begin
                m_cnt = 0;
            end else if (m_cnt == WORDS) begin
                if (cfg_commit) begin
                    m_active = m_pad[TOT_W-1:0];
                    m_cnt    = 0;
                end
            end else begin
                m_err = cfg_commit;
                if (cfg_valid) begin
                    m_pad[m_cnt*CFG_W +: CFG_W] = cfg_data;
                    m_cnt++;
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input logic [TOT_W-1:0] c, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = word_of(c, i);
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic commit_cfg();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [TOT_W-1:0] cfg7, cfg_oor, cfg_id, cfg_b, cfg_c, cfg_d, cfg_e, cfg_f, cfg_g;

    initial begin
        cfg7    = fill(7);
        cfg_oor = fill(7);
        cfg_oor[3*SEL_W +: SEL_W] = 5'd30;
        for (int k = 0; k < N_OUT; k++) cfg_id[k*SEL_W +: SEL_W] = SEL_W'(k);
        cfg_b = fill(2);
        cfg_c = fill(9);
        for (int k = 0; k < N_OUT; k++) cfg_d[k*SEL_W +: SEL_W] = SEL_W'((k * 5) % 24);
        cfg_e = fill(4);
        cfg_f = fill(11);
        cfg_g = fill(12);

        // reset then idle
        xbar_in = 24'h000001;
        step();
        step();
        check("rst_out", TOT_W'(xbar_out), '0);
        check("rst_ready", TOT_W'(cfg_ready), TOT_W'(1));
        check("rst_full", TOT_W'(cfg_full), '0);
        check("rst_err", TOT_W'(cfg_err), '0);
        check("rst_active", active_cfg, '0);
        reset = 1'b0;
        step();
        check("idle_out_in0", TOT_W'(xbar_out), TOT_W'(28'hFFFFFFF));

        // every field -> input 7
        xbar_in = 24'h000080;
        send_words(cfg7, 0, 4);
        check("load7_full", TOT_W'(cfg_full), TOT_W'(1));
        check("load7_ready", TOT_W'(cfg_ready), '0);
        commit_cfg();
        check("commit7_active", active_cfg, cfg7);
        check("commit7_out_old", TOT_W'(xbar_out), '0);
        check("commit7_ready", TOT_W'(cfg_ready), TOT_W'(1));
        step();
        check("commit7_out_new", TOT_W'(xbar_out), TOT_W'(28'hFFFFFFF));

        // field 3 out of range
        xbar_in = 24'hFFFFFF;
        send_words(cfg_oor, 0, 4);
        commit_cfg();
        step();
        check("oor_out", TOT_W'(xbar_out), TOT_W'(28'hFFFFFF7));

        // identity fields: outputs 24..27 select nonexistent inputs
        xbar_in = 24'hA5C3E1;
        send_words(cfg_id, 0, 4);
        commit_cfg();
        step();
        check("id_out", TOT_W'(xbar_out), TOT_W'(28'h0A5C3E1));

        // commit after 2 of 5 words
        xbar_in = 24'h000004;
        send_words(cfg_b, 0, 1);
        commit_cfg();
        check("illegal_err", TOT_W'(cfg_err), TOT_W'(1));
        check("illegal_active", active_cfg, cfg_id);
        check("illegal_state", TOT_W'(cfg_state), TOT_W'(LOAD));
        step();
        check("illegal_err_drop", TOT_W'(cfg_err), '0);
        send_words(cfg_b, 2, 4);
        check("illegal_then_full", TOT_W'(cfg_full), TOT_W'(1));
        commit_cfg();
        step();
        check("illegal_then_out", TOT_W'(xbar_out), TOT_W'(28'hFFFFFFF));

        // clear alongside the 4th word
        send_words(cfg_c, 0, 2);
        cfg_valid = 1'b1;
        cfg_data  = word_of(cfg_c, 3);
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        cfg_valid = 1'b0;
        check("clear_state", TOT_W'(cfg_state), TOT_W'(IDLE));
        check("clear_active", active_cfg, cfg_b);
        send_words(cfg_d, 0, 4);
        check("fresh_full", TOT_W'(cfg_full), TOT_W'(1));
        commit_cfg();
        check("fresh_active", active_cfg, cfg_d);

        // commit and valid together at FULL: the word waits for IDLE
        send_words(cfg_e, 0, 4);
        cfg_commit = 1'b1;
        cfg_valid  = 1'b1;
        cfg_data   = word_of(cfg_f, 0);
        step();
        cfg_commit = 1'b0;
        check("cv_active", active_cfg, cfg_e);
        check("cv_state", TOT_W'(cfg_state), TOT_W'(IDLE));
        step();
        cfg_valid = 1'b0;
        check("cv_word_taken", TOT_W'(cfg_state), TOT_W'(LOAD));
        send_words(cfg_f, 1, 4);
        commit_cfg();
        check("cv_next_active", active_cfg, cfg_f);

        // reset while FULL, with a commit on the same edge
        xbar_in = 24'hFFFFFF;
        send_words(cfg_g, 0, 4);
        reset      = 1'b1;
        cfg_commit = 1'b1;
        step();
        reset      = 1'b0;
        cfg_commit = 1'b0;
        check("rstfull_active", active_cfg, '0);
        check("rstfull_full", TOT_W'(cfg_full), '0);
        check("rstfull_out", TOT_W'(xbar_out), '0);
        step();
        check("rstfull_out_after", TOT_W'(xbar_out), TOT_W'(28'hFFFFFFF));

        repeat (3) step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
